mem_wb_hilo: RTL and testbench

MEM_WB_HILO -- requirements
Module: mem_wb_hilo

---
 rtl/mem_wb_hilo_pkg.sv | 33 +++
 rtl/mem_wb_hilo_hilo_reg.sv | 45 ++++
 rtl/mem_wb_hilo.sv | 80 ++++++++
 tb/tb_mem_wb_hilo.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_hilo_pkg.sv
// Shared constants and stage-update decode for the MEM/WB pipeline register
// and its architectural HI/LO storage.
package mem_wb_hilo_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int HILO_SEL_W = 2;
    localparam int HILO_HI    = 1;
    localparam int HILO_LO    = 0;

    typedef enum logic [1:0] {
        STAGE_LOAD   = 2'd0,
        STAGE_HOLD   = 2'd1,
        STAGE_BUBBLE = 2'd2
    } stage_op_t;

    // Flush beats bubble beats hold beats load. A WB-only stall has no legal
    // meaning, so it is folded into hold rather than dropping the instruction.
    function automatic stage_op_t stage_op(input logic flush,
                                           input logic stall_mem,
                                           input logic stall_wb);
        stage_op_t op;
        op = STAGE_LOAD;
        if (flush) begin
            op = STAGE_BUBBLE;
        end else if (stall_mem && !stall_wb) begin
            op = STAGE_BUBBLE;
        end else if (stall_wb) begin
            op = STAGE_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/mem_wb_hilo_hilo_reg.sv
// Architectural HI/LO registers written from the WB stage; optional read
// bypass enabled by the MEM_WB_HILO_BYPASS_EN macro.
module hilo_reg
    import mem_wb_hilo_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_wb,
    input  logic [HILO_SEL_W-1:0] write_hilo,
    input  logic [DATA_W-1:0]     hi_data,
    input  logic [DATA_W-1:0]     lo_data,
    output logic [DATA_W-1:0]     hi,
    output logic [DATA_W-1:0]     lo
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              hi_we;
    logic              lo_we;

    // A held instruction must not write until its stall releases.
    assign hi_we = write_hilo[HILO_HI] && !stall_wb;
    assign lo_we = write_hilo[HILO_LO] && !stall_wb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hi_we) hi_q <= hi_data;
            if (lo_we) lo_q <= lo_data;
        end
    end

`ifdef MEM_WB_HILO_BYPASS_EN
    assign hi = hi_we ? hi_data : hi_q;
    assign lo = lo_we ? lo_data : lo_q;
`else
    assign hi = hi_q;
    assign lo = lo_q;
`endif

endmodule

// File: rtl/mem_wb_hilo.sv
// MEM/WB pipeline register with flush/bubble/hold control feeding the
// HI/LO register file. Optional read bypass: MEM_WB_HILO_BYPASS_EN.
module mem_wb_hilo
    import mem_wb_hilo_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_mem_i,
    input  logic                  stall_wb_i,
    input  logic                  flush_i,
    input  logic [REG_ADDR_W-1:0] writeAddr_i,
    input  logic                  writeEnable_i,
    input  logic [HILO_SEL_W-1:0] writeHILO_i,
    input  logic [DATA_W-1:0]     HI_data_i,
    input  logic [DATA_W-1:0]     LO_data_i,
    output logic [REG_ADDR_W-1:0] writeAddr_o,
    output logic                  writeEnable_o,
    output logic [HILO_SEL_W-1:0] writeHILO_o,
    output logic [DATA_W-1:0]     HI_data_o,
    output logic [DATA_W-1:0]     LO_data_o,
    output logic [DATA_W-1:0]     HI_o,
    output logic [DATA_W-1:0]     LO_o
);

    stage_op_t op;

    always_comb begin
        op = stage_op(flush_i, stall_mem_i, stall_wb_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            writeAddr_o   <= '0;
            writeEnable_o <= 1'b0;
            writeHILO_o   <= '0;
            HI_data_o     <= '0;
            LO_data_o     <= '0;
        end else begin
            case (op)
                STAGE_BUBBLE: begin
                    writeAddr_o   <= '0;
                    writeEnable_o <= 1'b0;
                    writeHILO_o   <= '0;
                    HI_data_o     <= '0;
                    LO_data_o     <= '0;
                end
                STAGE_LOAD: begin
                    writeAddr_o   <= writeAddr_i;
                    writeEnable_o <= writeEnable_i;
                    writeHILO_o   <= writeHILO_i;
                    HI_data_o     <= HI_data_i;
                    LO_data_o     <= LO_data_i;
                end
                default: begin
                    writeAddr_o   <= writeAddr_o;
                    writeEnable_o <= writeEnable_o;
                    writeHILO_o   <= writeHILO_o;
                    HI_data_o     <= HI_data_o;
                    LO_data_o     <= LO_data_o;
                end
            endcase
        end
    end

    hilo_reg #(
        .DATA_W(DATA_W)
    ) u_hilo_reg (
        .clk       (clk),
        .rst       (rst),
        .stall_wb  (stall_wb_i),
        .write_hilo(writeHILO_o),
        .hi_data   (HI_data_o),
        .lo_data   (LO_data_o),
        .hi        (HI_o),
        .lo        (LO_o)
    );

endmodule

// File: tb/tb_mem_wb_hilo.sv
// Directed bench for mem_wb_hilo: reset, load, hold, bubble, flush,
// illegal-stall, HI/LO write timing and optional bypass visibility.
module tb_mem_wb_hilo;

    localparam int DATA_W = 32;

`ifdef MEM_WB_HILO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              stall_mem_i;
    logic              stall_wb_i;
    logic              flush_i;
    logic [4:0]        writeAddr_i;
    logic              writeEnable_i;
    logic [1:0]        writeHILO_i;
    logic [DATA_W-1:0] HI_data_i;
    logic [DATA_W-1:0] LO_data_i;
    logic [4:0]        writeAddr_o;
    logic              writeEnable_o;
    logic [1:0]        writeHILO_o;
    logic [DATA_W-1:0] HI_data_o;
    logic [DATA_W-1:0] LO_data_o;
    logic [DATA_W-1:0] HI_o;
    logic [DATA_W-1:0] LO_o;

    int checks = 0;
    int errors = 0;

    mem_wb_hilo #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_mem_i  (stall_mem_i),
        .stall_wb_i   (stall_wb_i),
        .flush_i      (flush_i),
        .writeAddr_i  (writeAddr_i),
        .writeEnable_i(writeEnable_i),
        .writeHILO_i  (writeHILO_i),
        .HI_data_i    (HI_data_i),
        .LO_data_i    (LO_data_i),
        .writeAddr_o  (writeAddr_o),
        .writeEnable_o(writeEnable_o),
        .writeHILO_o  (writeHILO_o),
        .HI_data_o    (HI_data_o),
        .LO_data_o    (LO_data_o),
        .HI_o         (HI_o),
        .LO_o         (LO_o)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sm, input logic sw, input logic fl,
                         input logic [4:0] addr, input logic we,
                         input logic [1:0] hl, input logic [DATA_W-1:0] hd,
                         input logic [DATA_W-1:0] ld);
        stall_mem_i   = sm;
        stall_wb_i    = sw;
        flush_i       = fl;
        writeAddr_i   = addr;
        writeEnable_i = we;
        writeHILO_i   = hl;
        HI_data_i     = hd;
        LO_data_i     = ld;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, '0, '0);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_stage(input string tag, input logic [4:0] addr, input logic we,
                               input logic [1:0] hl, input logic [DATA_W-1:0] hd,
                               input logic [DATA_W-1:0] ld);
        check({tag, ".addr"}, 64'(writeAddr_o), 64'(addr));
        check({tag, ".we"},   64'(writeEnable_o), 64'(we));
        check({tag, ".hilo"}, 64'(writeHILO_o), 64'(hl));
        check({tag, ".hid"},  64'(HI_data_o), 64'(hd));
        check({tag, ".lod"},  64'(LO_data_o), 64'(ld));
    endtask

    task automatic check_hilo(input string tag, input logic [DATA_W-1:0] hi,
                              input logic [DATA_W-1:0] lo);
        check({tag, ".HI"}, 64'(HI_o), 64'(hi));
        check({tag, ".LO"}, 64'(LO_o), 64'(lo));
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        check_stage("reset", 5'd0, 1'b0, 2'b00, '0, '0);
        check_hilo("reset", '0, '0);
        rst = 1'b0;

        // Load: write HI only
        drive(1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 2'b10, 32'hDEADBEEF, 32'h00000055);
        tick();
        check_stage("load", 5'd7, 1'b1, 2'b10, 32'hDEADBEEF, 32'h00000055);
        check_hilo("load_same", BYP ? 32'hDEADBEEF : 32'h0, 32'h0);
        idle();
        tick();
        check_hilo("load_next", 32'hDEADBEEF, 32'h0);
        check_stage("load_idle", 5'd0, 1'b0, 2'b00, '0, '0);

        // Stall: LO write held for 3 cycles, written once on release
        drive(1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 2'b01, 32'h0000FFFF, 32'h12345678);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 2'b11, 32'h99999999, 32'h88888888);
        for (int i = 0; i < 3; i++) begin
            check_stage("hold", 5'd3, 1'b1, 2'b01, 32'h0000FFFF, 32'h12345678);
            check_hilo("hold", 32'hDEADBEEF, 32'h0);
            tick();
        end
        check_stage("hold_last", 5'd3, 1'b1, 2'b01, 32'h0000FFFF, 32'h12345678);
        idle();
        #1;
        check_hilo("release_same", 32'hDEADBEEF, BYP ? 32'h12345678 : 32'h0);
        tick();
        check_hilo("release_next", 32'hDEADBEEF, 32'h12345678);
        check_stage("release_idle", 5'd0, 1'b0, 2'b00, '0, '0);

        // Bubble: MEM stall with WB free inserts a nop
        drive(1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 2'b00, 32'h5, 32'h6);
        tick();
        check_stage("pre_bubble", 5'd5, 1'b1, 2'b00, 32'h5, 32'h6);
        drive(1'b1, 1'b0, 1'b0, 5'd6, 1'b1, 2'b11, 32'h00000BAD, 32'h00000BAD);
        tick();
        check_stage("bubble", 5'd0, 1'b0, 2'b00, '0, '0);
        idle();
        tick();
        check_hilo("bubble", 32'hDEADBEEF, 32'h12345678);

        // Flush wins over hold
        drive(1'b0, 1'b0, 1'b0, 5'd11, 1'b1, 2'b00, 32'hA5, 32'h5A);
        tick();
        check_stage("pre_flush", 5'd11, 1'b1, 2'b00, 32'hA5, 32'h5A);
        drive(1'b1, 1'b1, 1'b1, 5'd12, 1'b1, 2'b11, 32'h1, 32'h2);
        tick();
        check_stage("flush", 5'd0, 1'b0, 2'b00, '0, '0);
        check_hilo("flush", 32'hDEADBEEF, 32'h12345678);

        // WB-only stall treated as hold
        drive(1'b0, 1'b0, 1'b0, 5'd4, 1'b1, 2'b00, 32'h44, 32'h45);
        tick();
        drive(1'b0, 1'b1, 1'b0, 5'd13, 1'b0, 2'b11, 32'h7, 32'h8);
        tick();
        check_stage("wb_only_stall", 5'd4, 1'b1, 2'b00, 32'h44, 32'h45);

        // Dual HI/LO write and bypass visibility
        drive(1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 2'b11, 32'hA, 32'hB);
        tick();
        check_stage("dual", 5'd1, 1'b0, 2'b11, 32'hA, 32'hB);
        check_hilo("dual_same", BYP ? 32'hA : 32'hDEADBEEF, BYP ? 32'hB : 32'h12345678);
        idle();
        tick();
        check_hilo("dual_next", 32'hA, 32'hB);

        // Mid-cycle asynchronous reset with an instruction in flight
        drive(1'b0, 1'b0, 1'b0, 5'd31, 1'b1, 2'b11, 32'h111, 32'h222);
        tick();
        check_stage("pre_rst", 5'd31, 1'b1, 2'b11, 32'h111, 32'h222);
        #2;
        rst = 1'b1;
        #1;
        check_stage("async_rst", 5'd0, 1'b0, 2'b00, '0, '0);
        check_hilo("async_rst", '0, '0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 2'b01, 32'h0, 32'h77);
        tick();
        check_stage("post_rst", 5'd2, 1'b1, 2'b01, 32'h0, 32'h77);
        check_hilo("post_rst_same", 32'h0, BYP ? 32'h77 : 32'h0);
        idle();
        tick();
        check_hilo("post_rst_next", 32'h0, 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
